// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: four-channel motor PWM with a shared period counter, an
// arm/run/fault state machine, per-channel duty slew limiting and a host watchdog.

// One channel: holds the current and target duty, slews current toward target, drives the pin.
module motor_ramp_lane #(
    parameter int DUTY_W    = 16,
    parameter int RAMP_STEP = 10,
    parameter int ARM_DUTY  = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_en,
    input  logic [DUTY_W-1:0] cnt,
    input  logic              ramp_en,
    input  logic              load_arm,
    input  logic              clr_all,
    input  logic              zero_tgt,
    input  logic              set_en,
    input  logic [DUTY_W-1:0] set_duty,
    output logic              pwm,
    output logic [DUTY_W-1:0] cur
);
    localparam logic [DUTY_W-1:0] STEP  = DUTY_W'(RAMP_STEP);
    localparam logic [DUTY_W-1:0] ARM_D = DUTY_W'(ARM_DUTY);

    logic [DUTY_W-1:0] tgt;
    logic [DUTY_W-1:0] ramp_nxt;

    // Next ramped duty: snap to target when within one step, otherwise move one step.
    always_comb begin
        ramp_nxt = cur;
        if (tgt > cur)
            ramp_nxt = ((tgt - cur) <= STEP) ? tgt : cur + STEP;
        else if (cur > tgt)
            ramp_nxt = ((cur - tgt) <= STEP) ? tgt : cur - STEP;
    end

    // Duty registers and registered PWM pin; disarm/arm loads take priority over ramp and set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= '0;
            tgt <= '0;
            pwm <= 1'b0;
        end else begin
            pwm <= pwm_en && (cnt < cur);
            if (clr_all) begin
                cur <= '0;
                tgt <= '0;
            end else if (load_arm) begin
                cur <= ARM_D;
                tgt <= ARM_D;
            end else begin
                if (ramp_en)
                    cur <= ramp_nxt;
                if (zero_tgt)
                    tgt <= '0;
                else if (set_en)
                    tgt <= set_duty;
            end
        end
    end
endmodule

module motor_ramp_ctrl #(
    parameter int PERIOD_CYCLES = 1000,
    parameter int DUTY_W        = 16,
    parameter int RAMP_STEP     = 10,
    parameter int ARM_DUTY      = 50,
    parameter int ARM_PERIODS   = 50,
    parameter int WDOG_PERIODS  = 500
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [1:0]            i_cmd_op,
    input  logic [1:0]            i_cmd_ch,
    input  logic [DUTY_W-1:0]     i_cmd_duty,
    output logic [3:0]            o_pwm,
    output logic [1:0]            o_state,
    output logic                  o_fault,
    output logic                  o_period_tick,
    output logic [4*DUTY_W-1:0]   o_duty_flat
);
    localparam int NUM_LANES = 4;
    localparam int ARM_W     = $clog2(ARM_PERIODS + 1);
    localparam int WDOG_W    = $clog2(WDOG_PERIODS + 1);
    localparam logic [DUTY_W-1:0] PERIOD_D = DUTY_W'(PERIOD_CYCLES);
    localparam logic [ARM_W-1:0]  ARM_LAST = ARM_W'(ARM_PERIODS - 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_PERIODS);
    localparam logic [1:0] OP_SET    = 2'd0;
    localparam logic [1:0] OP_ARM    = 2'd1;
    localparam logic [1:0] OP_DISARM = 2'd2;

    typedef enum logic [1:0] {DISARMED = 2'd0, ARMING = 2'd1, RUNNING = 2'd2, FAULT = 2'd3} state_t;

    typedef struct packed {
        logic [1:0]        op;
        logic [1:0]        ch;
        logic [DUTY_W-1:0] duty;
    } cmd_t;

    state_t                               state;
    cmd_t                                 cmd;
    logic [DUTY_W-1:0]                    cnt;
    logic [DUTY_W-1:0]                    duty_clamp;
    logic [ARM_W-1:0]                     arm_cnt;
    logic [WDOG_W-1:0]                    wdog;
    logic                                 tick, accept, arm_cmd, disarm_cmd;
    logic                                 wdog_expire, ramp_en, pwm_en;
    logic [NUM_LANES-1:0]                 set_en;
    logic [NUM_LANES-1:0][DUTY_W-1:0]     cur;

    assign cmd         = '{op: i_cmd_op, ch: i_cmd_ch, duty: i_cmd_duty};
    assign tick        = (cnt == PERIOD_D - 1'b1);
    // Arming stalls the host rather than dropping commands.
    assign o_cmd_ready = (state != ARMING);
    assign accept      = i_cmd_valid && o_cmd_ready;
    assign arm_cmd     = accept && (cmd.op == OP_ARM) && (state == DISARMED);
    assign disarm_cmd  = accept && (cmd.op == OP_DISARM);
    // An accepted command on the expiry tick refreshes the watchdog instead of faulting.
    assign wdog_expire = (state == RUNNING) && tick && !accept && (wdog >= WDOG_MAX - 1'b1);
    assign ramp_en     = tick && ((state == RUNNING) || (state == FAULT));
    assign pwm_en      = (state != DISARMED);
    assign duty_clamp  = (cmd.duty > PERIOD_D) ? PERIOD_D : cmd.duty;
    assign o_state     = state;
    assign o_fault     = (state == FAULT);
    assign o_duty_flat = cur;

    // Shared period counter and the registered end-of-period pulse.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt           <= '0;
            o_period_tick <= 1'b0;
        end else begin
            cnt           <= tick ? '0 : cnt + 1'b1;
            o_period_tick <= tick;
        end
    end

    // Arm/run/fault state machine with the arming period counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= DISARMED;
            arm_cnt <= '0;
        end else begin
            case (state)
                DISARMED: begin
                    if (arm_cmd) begin
                        state   <= ARMING;
                        arm_cnt <= '0;
                    end
                end
                ARMING: begin
                    if (tick) begin
                        arm_cnt <= arm_cnt + 1'b1;
                        if (arm_cnt == ARM_LAST)
                            state <= RUNNING;
                    end
                end
                RUNNING: begin
                    if (disarm_cmd)
                        state <= DISARMED;
                    else if (wdog_expire)
                        state <= FAULT;
                end
                default: begin
                    if (disarm_cmd)
                        state <= DISARMED;
                end
            endcase
        end
    end

    // Watchdog counts periods without an accepted command, only while running.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            wdog <= '0;
        else if ((state != RUNNING) || accept)
            wdog <= '0;
        else if (tick && (wdog != WDOG_MAX))
            wdog <= wdog + 1'b1;
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign set_en[g] = accept && (state == RUNNING) && (cmd.op == OP_SET) && (cmd.ch == 2'(g));

        motor_ramp_lane #(
            .DUTY_W    (DUTY_W),
            .RAMP_STEP (RAMP_STEP),
            .ARM_DUTY  (ARM_DUTY)
        ) u_lane (
            .clk      (i_clk),
            .rst      (i_reset),
            .pwm_en   (pwm_en),
            .cnt      (cnt),
            .ramp_en  (ramp_en),
            .load_arm (arm_cmd),
            .clr_all  (disarm_cmd),
            .zero_tgt (wdog_expire),
            .set_en   (set_en[g]),
            .set_duty (duty_clamp),
            .pwm      (o_pwm[g]),
            .cur      (cur[g])
        );
    end
endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// tb_motor_ramp_ctrl: directed scenarios on a shortened configuration
// (100-cycle period, 5 arming periods, 20-period watchdog).
module tb_motor_ramp_ctrl;
    localparam int P  = 100;
    localparam int W  = 16;
    localparam int AP = 5;
    localparam int WD = 20;

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b1;
    logic            i_cmd_valid = 1'b0;
    logic            o_cmd_ready;
    logic [1:0]      i_cmd_op = 2'd0;
    logic [1:0]      i_cmd_ch = 2'd0;
    logic [W-1:0]    i_cmd_duty = '0;
    logic [3:0]      o_pwm;
    logic [1:0]      o_state;
    logic            o_fault;
    logic            o_period_tick;
    logic [4*W-1:0]  o_duty_flat;

    int total = 0;
    int bad   = 0;

    motor_ramp_ctrl #(
        .PERIOD_CYCLES (P),
        .DUTY_W        (W),
        .RAMP_STEP     (10),
        .ARM_DUTY      (50),
        .ARM_PERIODS   (AP),
        .WDOG_PERIODS  (WD)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_op      (i_cmd_op),
        .i_cmd_ch      (i_cmd_ch),
        .i_cmd_duty    (i_cmd_duty),
        .o_pwm         (o_pwm),
        .o_state       (o_state),
        .o_fault       (o_fault),
        .o_period_tick (o_period_tick),
        .o_duty_flat   (o_duty_flat)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [W-1:0] duty(input int n);
        return o_duty_flat[n*W +: W];
    endfunction

    // Wait for the next visible period tick (sampled on negedges), bounded.
    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (o_period_tick !== 1'b1 && n < 3*P);
        total++;
        if (o_period_tick !== 1'b1) begin
            bad++;
            $display("FAIL tick_timeout got=%b exp=1", o_period_tick);
        end
    endtask

    // Present a command at a negedge, hold it until accepted (bounded), drop valid after.
    task automatic send_cmd(input logic [1:0] op, input logic [1:0] ch, input logic [W-1:0] d,
                            input int max_wait, output int waited);
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_ch    = ch;
        i_cmd_duty  = d;
        waited      = 0;
        while (o_cmd_ready !== 1'b1 && waited < max_wait) begin
            @(negedge i_clk);
            waited++;
        end
        @(posedge i_clk);
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        int n, hi;
        i_reset = 1'b1;
        repeat (3) @(negedge i_clk);
        total++; if (o_pwm !== 4'h0) begin bad++; $display("FAIL reset_pwm got=%h exp=0", o_pwm); end
        total++; if (o_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", o_state); end
        total++; if (o_fault !== 1'b0 || o_period_tick !== 1'b0) begin
            bad++; $display("FAIL reset_flags got=%b%b exp=00", o_fault, o_period_tick); end
        total++; if (o_duty_flat !== '0) begin bad++; $display("FAIL reset_duty got=%h exp=0", o_duty_flat); end
        i_reset = 1'b0;
        n = 0;
        do begin @(negedge i_clk); n++; end while (o_period_tick !== 1'b1 && n < 3*P);
        total++; if (n !== P) begin bad++; $display("FAIL first_tick got=%0d exp=%0d", n, P); end
        total++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", o_cmd_ready); end
        n = 0; hi = 0;
        do begin
            @(negedge i_clk); n++;
            if (o_pwm !== 4'h0) hi++;
        end while (o_period_tick !== 1'b1 && n < 3*P);
        total++; if (n !== P) begin bad++; $display("FAIL tick_spacing got=%0d exp=%0d", n, P); end
        total++; if (hi !== 0) begin bad++; $display("FAIL idle_pwm_high got=%0d exp=0", hi); end
    endtask

    task automatic test_arm();
        int w;
        int hi[4];
        wait_tick();
        send_cmd(2'd1, 2'd0, '0, 5, w);
        total++; if (o_state !== 2'd1 || o_cmd_ready !== 1'b0) begin
            bad++; $display("FAIL arming_state got=%0d/%b exp=1/0", o_state, o_cmd_ready); end
        for (int c = 0; c < 4; c++) begin
            total++; if (duty(c) !== 16'd50) begin bad++; $display("FAIL arm_duty ch%0d got=%0d exp=50", c, duty(c)); end
        end
        send_cmd(2'd3, 2'd0, '0, 2*AP*P, w);
        total++; if (w !== AP*P - 1) begin bad++; $display("FAIL arm_stall got=%0d exp=%0d", w, AP*P - 1); end
        total++; if (o_state !== 2'd2) begin bad++; $display("FAIL run_state got=%0d exp=2", o_state); end
        for (int c = 0; c < 4; c++) hi[c] = 0;
        repeat (P) begin
            @(negedge i_clk);
            for (int c = 0; c < 4; c++) if (o_pwm[c] === 1'b1) hi[c]++;
        end
        for (int c = 0; c < 4; c++) begin
            total++; if (hi[c] !== 50) begin bad++; $display("FAIL arm_pwm_high ch%0d got=%0d exp=50", c, hi[c]); end
        end
    endtask

    task automatic test_ramp();
        int w;
        int exp_d[5];
        exp_d = '{60, 70, 80, 85, 85};
        send_cmd(2'd0, 2'd2, 16'd85, 5, w);
        for (int i = 0; i < 5; i++) begin
            wait_tick();
            total++; if (duty(2) !== exp_d[i][W-1:0]) begin
                bad++; $display("FAIL ramp_up step%0d got=%0d exp=%0d", i, duty(2), exp_d[i]); end
        end
        total++; if (duty(0) !== 16'd50 || duty(1) !== 16'd50 || duty(3) !== 16'd50) begin
            bad++; $display("FAIL ramp_others got=%0d,%0d,%0d exp=50,50,50", duty(0), duty(1), duty(3)); end
    endtask

    task automatic test_clamp();
        int w, hi;
        int exp_d[5];
        exp_d = '{60, 70, 80, 90, 100};
        send_cmd(2'd0, 2'd0, 16'd5000, 5, w);
        for (int i = 0; i < 5; i++) begin
            wait_tick();
            total++; if (duty(0) !== exp_d[i][W-1:0]) begin
                bad++; $display("FAIL clamp_ramp step%0d got=%0d exp=%0d", i, duty(0), exp_d[i]); end
        end
        @(negedge i_clk);
        hi = 0;
        repeat (P) begin
            @(negedge i_clk);
            if (o_pwm[0] === 1'b1) hi++;
        end
        total++; if (hi !== P) begin bad++; $display("FAIL full_duty_high got=%0d exp=%0d", hi, P); end
        total++; if (duty(2) !== 16'd85) begin bad++; $display("FAIL clamp_ch2 got=%0d exp=85", duty(2)); end
    endtask

    task automatic test_watchdog();
        int w, n;
        wait_tick();
        send_cmd(2'd3, 2'd0, '0, 5, w);
        n = 0;
        do begin wait_tick(); n++; end while (o_state !== 2'd3 && n < 2*WD);
        total++; if (n !== WD) begin bad++; $display("FAIL wdog_periods got=%0d exp=%0d", n, WD); end
        total++; if (o_fault !== 1'b1) begin bad++; $display("FAIL wdog_fault got=%b exp=1", o_fault); end
        total++; if (duty(0) !== 16'd100 || duty(2) !== 16'd85) begin
            bad++; $display("FAIL fault_entry_duty got=%0d,%0d exp=100,85", duty(0), duty(2)); end
        wait_tick();
        total++; if (duty(0) !== 16'd90 || duty(1) !== 16'd40 || duty(2) !== 16'd75 || duty(3) !== 16'd40) begin
            bad++; $display("FAIL fault_ramp1 got=%0d,%0d,%0d,%0d exp=90,40,75,40", duty(0), duty(1), duty(2), duty(3)); end
        repeat (9) wait_tick();
        total++; if (o_duty_flat !== '0) begin bad++; $display("FAIL fault_ramp_zero got=%h exp=0", o_duty_flat); end
        send_cmd(2'd1, 2'd0, '0, 5, w);
        total++; if (o_state !== 2'd3) begin bad++; $display("FAIL fault_arm_ignored got=%0d exp=3", o_state); end
        send_cmd(2'd2, 2'd0, '0, 5, w);
        total++; if (o_state !== 2'd0 || o_fault !== 1'b0 || o_cmd_ready !== 1'b1) begin
            bad++; $display("FAIL fault_disarm got=%0d/%b/%b exp=0/0/1", o_state, o_fault, o_cmd_ready); end
    endtask

    task automatic test_reset_mid();
        int w, n;
        send_cmd(2'd1, 2'd0, '0, 5, w);
        send_cmd(2'd3, 2'd0, '0, 2*AP*P, w);
        total++; if (o_state !== 2'd2) begin bad++; $display("FAIL rearm_state got=%0d exp=2", o_state); end
        n = 0;
        do begin @(negedge i_clk); n++; end while (o_pwm !== 4'hF && n < 3*P);
        total++; if (o_pwm !== 4'hF) begin bad++; $display("FAIL mid_pwm_high got=%h exp=f", o_pwm); end
        i_reset = 1'b1;
        #1;
        total++; if (o_pwm !== 4'h0) begin bad++; $display("FAIL async_reset_pwm got=%h exp=0", o_pwm); end
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        total++; if (o_state !== 2'd0 || o_duty_flat !== '0) begin
            bad++; $display("FAIL post_reset got=%0d/%h exp=0/0", o_state, o_duty_flat); end
        total++; if (o_cmd_ready !== 1'b1 || o_pwm !== 4'h0) begin
            bad++; $display("FAIL post_reset_io got=%b/%h exp=1/0", o_cmd_ready, o_pwm); end
    endtask

    initial begin
        test_reset();
        test_arm();
        test_ramp();
        test_clamp();
        test_watchdog();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
